// File: rtl/iiitb_seq_8by4_div_pkg.sv
// Shared definitions for the sequential signed divider: default widths,
// FSM state type and the iteration-counter width.
package iiitb_seq_8by4_div_pkg;

  // Default dividend/quotient width.
  localparam int DEF_DW = 8;

  // Default divisor/remainder width.
  localparam int DEF_VW = 4;

  // Bits needed for a counter that has to reach the given iteration count.
  function automatic int cntWidth(input int iters);
    return $clog2(iters + 1);
  endfunction

  // Iteration-counter width for the default dividend width.
  localparam int CNT_W = cntWidth(DEF_DW);

  // Divider control states: idle, restoring iterations, sign fix-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } divState_t;

endpackage

// File: rtl/iiitb_seq_8by4_div_if.sv
// Operand/result bundle of the divider. The master issues load/D/M and
// receives the registered quotient, remainder and status flags.
interface iiitb_seq_8by4_div_if
  import iiitb_seq_8by4_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
);

  logic          load;
  logic [DW-1:0] D;
  logic [VW-1:0] M;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          busy;
  logic          done;
  logic          dbz;
  logic          ovf;

  modport master (
    output load, D, M,
    input  Q, R, busy, done, dbz, ovf
  );

  modport slave (
    input  load, D, M,
    output Q, R, busy, done, dbz, ovf
  );

endinterface

// File: rtl/iiitb_div_abs.sv
// Two's-complement conditional negate. Used both to take operand
// magnitudes (i_neg = sign bit) and to re-apply signs to the results.
// The output may be narrower than the input when the caller knows the
// value fits; the negate is done at the wider of the two widths.
module iiitb_div_abs #(
  parameter int W  = 8,
  parameter int OW = W
) (
  input  logic [W-1:0]  i_val,
  input  logic          i_neg,
  output logic [OW-1:0] o_val
);

  localparam int EW = (W > OW) ? W : OW;

  assign o_val = OW'(i_neg ? (~EW'(i_val) + EW'(1)) : EW'(i_val));

endmodule

// File: rtl/iiitb_seq_8by4_div.sv
// Sequential signed divider: operands are reduced to magnitudes, divided
// by DW unsigned restoring steps, then the signs are restored so that the
// quotient truncates toward zero and the remainder follows the dividend.
module iiitb_seq_8by4_div
  import iiitb_seq_8by4_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input logic                  clk,
  input logic                  reset,
  iiitb_seq_8by4_div_if.slave  bus
);

  localparam int CW = cntWidth(DW);

  divState_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quo;
  logic [VW:0]   r_rem;
  logic [VW:0]   r_mag;
  logic          r_negQ;
  logic          r_negR;
  logic          r_zero;
  logic [DW-1:0] r_Q;
  logic [VW-1:0] r_R;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;
  logic          r_ovf;

  logic [DW-1:0] w_absD;
  logic [VW:0]   w_mExt;
  logic [VW:0]   w_absM;
  logic [VW+1:0] w_part;
  logic [VW+1:0] w_diff;
  logic [DW-1:0] w_fixQ;
  logic [VW-1:0] w_fixR;
  logic          w_mZero;
  logic          w_ovf;

  // The divisor is sign-extended one bit so that |-2^(VW-1)| is representable.
  assign w_mExt  = {bus.M[VW-1], bus.M};
  assign w_mZero = (bus.M == '0);

  iiitb_div_abs #(.W(DW), .OW(DW)) u_absD (
    .i_val (bus.D),
    .i_neg (bus.D[DW-1]),
    .o_val (w_absD)
  );

  iiitb_div_abs #(.W(VW + 1), .OW(VW + 1)) u_absM (
    .i_val (w_mExt),
    .i_neg (bus.M[VW-1]),
    .o_val (w_absM)
  );

  // Partial remainder shifted left with the next dividend bit; the extra top
  // bit keeps the trial subtraction's borrow visible in w_diff.
  assign w_part = {r_rem, r_quo[DW-1]};
  assign w_diff = w_part - {1'b0, r_mag};

  iiitb_div_abs #(.W(DW), .OW(DW)) u_fixQ (
    .i_val (r_quo),
    .i_neg (r_negQ),
    .o_val (w_fixQ)
  );

  iiitb_div_abs #(.W(VW + 1), .OW(VW)) u_fixR (
    .i_val (r_rem),
    .i_neg (r_negR),
    .o_val (w_fixR)
  );

  // A positive quotient whose magnitude needs the top bit cannot be represented.
  assign w_ovf = !r_negQ && r_quo[DW-1];

  // Control FSM with the datapath and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_mag   <= '0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
      r_zero  <= 1'b0;
      r_Q     <= '0;
      r_R     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_quo   <= w_absD;
            r_rem   <= '0;
            r_mag   <= w_absM;
            r_negR  <= bus.D[DW-1];
            r_negQ  <= bus.D[DW-1] ^ bus.M[VW-1];
            r_zero  <= w_mZero;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= w_mZero ? FIX : CALC;
          end
        end
        CALC: begin
          if (w_diff[VW+1]) begin
            r_rem <= w_part[VW:0];
            r_quo <= {r_quo[DW-2:0], 1'b0};
          end else begin
            r_rem <= w_diff[VW:0];
            r_quo <= {r_quo[DW-2:0], 1'b1};
          end
          if (r_cnt == CW'(DW - 1)) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIX: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
          if (r_zero) begin
            r_Q   <= '0;
            r_R   <= '0;
            r_dbz <= 1'b1;
            r_ovf <= 1'b0;
          end else if (w_ovf) begin
            r_Q   <= {1'b1, {(DW-1){1'b0}}};
            r_R   <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b1;
          end else begin
            r_Q   <= w_fixQ;
            r_R   <= w_fixR;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Q    = r_Q;
  assign bus.R    = r_R;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dbz  = r_dbz;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_iiitb_seq_8by4_div.sv
// Self-checking bench for the sequential divider: a transaction-level model
// (integer division plus a cycle countdown) is compared against the DUT on
// every cycle, with literal expectations for the hand-worked examples.
module tb_iiitb_seq_8by4_div;

  localparam int DW = 8;
  localparam int VW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   chkEn;

  iiitb_seq_8by4_div_if #(.DW(DW), .VW(VW)) bus ();

  iiitb_seq_8by4_div #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference signed division with truncation toward zero.
  task automatic refDiv(input logic [7:0] d, input logic [3:0] m,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic dz, output logic ov);
    int sd, sm, qi, ri;
    sd = int'($signed(d));
    sm = int'($signed(m));
    dz = 1'b0;
    ov = 1'b0;
    q  = '0;
    r  = '0;
    if (sm == 0) begin
      dz = 1'b1;
    end else begin
      qi = sd / sm;
      ri = sd % sm;
      if (qi > 127) begin
        ov = 1'b1;
        q  = 8'h80;
      end else begin
        q = qi[7:0];
        r = ri[3:0];
      end
    end
  endtask

  // Model state.
  int         mRemain;
  logic [7:0] pQ, expQ;
  logic [3:0] pR, expR;
  logic       pDbz, pOvf, expDbz, expOvf, expBusy, expDone;

  // Behavioural model: latency countdown plus arithmetic result.
  always @(posedge clk or negedge reset) begin : modelProc
    logic [7:0] tq;
    logic [3:0] tr;
    logic       tdz, tov;
    if (!reset) begin
      mRemain <= 0;
      expBusy <= 1'b0;
      expDone <= 1'b0;
      expQ    <= '0;
      expR    <= '0;
      expDbz  <= 1'b0;
      expOvf  <= 1'b0;
    end else begin
      expDone <= 1'b0;
      if (mRemain > 0) begin
        mRemain <= mRemain - 1;
        if (mRemain == 1) begin
          expQ    <= pQ;
          expR    <= pR;
          expDbz  <= pDbz;
          expOvf  <= pOvf;
          expDone <= 1'b1;
          expBusy <= 1'b0;
        end
      end else if (bus.load) begin
        refDiv(bus.D, bus.M, tq, tr, tdz, tov);
        pQ      <= tq;
        pR      <= tr;
        pDbz    <= tdz;
        pOvf    <= tov;
        mRemain <= (bus.M == '0) ? 1 : DW + 1;
        expBusy <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("busy", 32'(bus.busy), 32'(expBusy));
      checkOutput("done", 32'(bus.done), 32'(expDone));
      checkOutput("Q",    32'(bus.Q),    32'(expQ));
      checkOutput("R",    32'(bus.R),    32'(expR));
      checkOutput("dbz",  32'(bus.dbz),  32'(expDbz));
      checkOutput("ovf",  32'(bus.ovf),  32'(expOvf));
    end
  end

  // One-cycle load pulse; operands are scrambled afterwards on purpose.
  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.load = 1'b1;
    bus.D    = d;
    bus.M    = m;
    @(negedge clk);
    bus.load = 1'b0;
    bus.D    = 8'($urandom);
    bus.M    = 4'($urandom);
  endtask

  // Count negedges until done, bounded.
  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
      cyc = -1;
    end
  endtask

  // Check the visible result against hand-worked values.
  task automatic checkResult(input string tag, input logic [7:0] q, input logic [3:0] r,
                             input logic dz, input logic ov);
    checkOutput({tag, "_Q"},   32'(bus.Q),   32'(q));
    checkOutput({tag, "_R"},   32'(bus.R),   32'(r));
    checkOutput({tag, "_dbz"}, 32'(bus.dbz), 32'(dz));
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(ov));
  endtask

  // Pin the reference model on a worked example.
  task automatic pinModel(input string tag, input logic [7:0] d, input logic [3:0] m,
                          input logic [7:0] q, input logic [3:0] r);
    logic [7:0] tq;
    logic [3:0] tr;
    logic tdz, tov;
    refDiv(d, m, tq, tr, tdz, tov);
    checkOutput({tag, "_modelQ"}, 32'(tq), 32'(q));
    checkOutput({tag, "_modelR"}, 32'(tr), 32'(r));
  endtask

  initial begin
    int  cyc;
    bit  sawDone;
    checks   = 0;
    errors   = 0;
    chkEn    = 1'b0;
    bus.load = 1'b0;
    bus.D    = '0;
    bus.M    = '0;
    reset    = 1'b1;

    pinModel("m30", 8'h1E, 4'hA, 8'hFB, 4'h0);
    pinModel("m86", 8'hAA, 4'h5, 8'hEF, 4'hF);
    pinModel("m100", 8'h64, 4'h7, 8'h0E, 4'h2);
    pinModel("m128", 8'h80, 4'hF, 8'h80, 4'h0);

    #3 reset = 1'b0;
    #1;
    checkResult("reset", 8'h00, 4'h0, 1'b0, 1'b0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chkEn = 1'b1;

    $display("[TB] 30 / -6");
    applyStimulus(8'h1E, 4'hA);
    waitDone(cyc);
    checkOutput("lat_30", 32'(cyc), 32'd9);
    checkResult("div30", 8'hFB, 4'h0, 1'b0, 1'b0);
    checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
    checkResult("hold30", 8'hFB, 4'h0, 1'b0, 1'b0);

    $display("[TB] -86 / 5");
    applyStimulus(8'hAA, 4'h5);
    waitDone(cyc);
    checkResult("divm86", 8'hEF, 4'hF, 1'b0, 1'b0);

    $display("[TB] 100 / 7 with ignored load");
    applyStimulus(8'h64, 4'h7);
    repeat (2) @(negedge clk);
    bus.load = 1'b1;
    bus.D    = 8'h11;
    bus.M    = 4'h0;
    @(negedge clk);
    bus.load = 1'b0;
    waitDone(cyc);
    checkResult("div100", 8'h0E, 4'h2, 1'b0, 1'b0);
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("single_done", 32'(sawDone), 32'd0);

    $display("[TB] overflow and divide by zero");
    applyStimulus(8'h80, 4'hF);
    waitDone(cyc);
    checkResult("ovf", 8'h80, 4'h0, 1'b0, 1'b1);
    applyStimulus(8'h80, 4'h0);
    waitDone(cyc);
    checkOutput("lat_dbz", 32'(cyc), 32'd1);
    checkResult("dbz", 8'h00, 4'h0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-division");
    applyStimulus(8'h55, 4'h3);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkResult("midreset", 8'h00, 4'h0, 1'b0, 1'b0);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sawDone = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("no_done_after_reset", 32'(sawDone), 32'd0);
    applyStimulus(8'h55, 4'h3);
    waitDone(cyc);
    checkOutput("lat_after_reset", 32'(cyc), 32'd9);
    checkResult("div85", 8'h1C, 4'h1, 1'b0, 1'b0);

    $display("[TB] back-to-back with load held");
    @(negedge clk);
    bus.load = 1'b1;
    repeat (35) begin
      bus.D = 8'($urandom);
      bus.M = 4'($urandom);
      @(negedge clk);
    end
    bus.load = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] random traffic");
    repeat (3000) begin
      @(negedge clk);
      bus.load = ($urandom_range(0, 3) == 0);
      bus.D    = 8'($urandom);
      bus.M    = 4'($urandom);
      case ($urandom_range(0, 9))
        0: bus.M = 4'h0;
        1: begin bus.D = 8'h80; bus.M = 4'hF; end
        2: bus.M = 4'h8;
        default: ;
      endcase
    end
    bus.load = 1'b0;
    repeat (15) @(negedge clk);

    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
